// File: rtl/l1_cache_pkg.sv
// rtl/l1_cache_pkg.sv - shared widths, FSM encoding and helpers for the L1 cache controller
package l1_cache_pkg;

  localparam int ADDR_W        = 32;
  localparam int DATA_W        = 32;
  localparam int LINES_DEFAULT = 64;

  // Controller FSM encoding, kept as plain constants for legacy tooling
  typedef logic [2:0] state_t;
  localparam state_t IDLE     = 3'd0;
  localparam state_t LOOKUP   = 3'd1;
  localparam state_t MEM_REQ  = 3'd2;
  localparam state_t MEM_WAIT = 3'd3;
  localparam state_t RESP     = 3'd4;

  // Index width for a direct-mapped array of the given number of lines
  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  // Tag width: everything above the index and the 2-bit byte offset
  function automatic int tag_w(input int addr_w, input int lines);
    return addr_w - $clog2(lines) - 2;
  endfunction

  // Event counters stick at all-ones instead of wrapping
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/l1_tag_data_array.sv
// rtl/l1_tag_data_array.sv - valid/tag/data flop storage with one read and one write port
module l1_tag_data_array #(
  parameter int LINES  = 64,
  parameter int IDX_W  = 6,
  parameter int TAG_W  = 24,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic              wr_fill,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data
);

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  // Combinational read of the addressed line
  always_comb begin
    rd_valid = valid_q[rd_idx];
    rd_tag   = tag_q[rd_idx];
    rd_data  = data_q[rd_idx];
  end

  // Valid bits are the only state that must be cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_en && wr_fill) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Data is written on store hits and fills; tag only on fills
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_q[wr_idx] <= wr_data;
      if (wr_fill) begin
        tag_q[wr_idx] <= wr_tag;
      end
    end
  end

endmodule

// File: rtl/l1_cache_ctrl.sv
// rtl/l1_cache_ctrl.sv - direct-mapped write-through no-write-allocate L1 cache controller
module l1_cache_ctrl
  import l1_cache_pkg::*;
#(
  parameter int LINES = LINES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req_valid,
  input  logic              cpu_req_store,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [DATA_W-1:0] cpu_req_wdata,
  output logic              cpu_req_ready,
  output logic              cpu_resp_valid,
  output logic [DATA_W-1:0] cpu_resp_rdata,
  output logic              l1_mem_valid,
  output logic              l1_mem_store,
  output logic [ADDR_W-1:0] l1_mem_addr,
  output logic [DATA_W-1:0] l1_mem_wdata,
  input  logic [DATA_W-1:0] mem_l1_rdata,
  input  logic              mem_l1_valid,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  localparam int IDX_W = idx_w(LINES);
  localparam int TAG_W = tag_w(ADDR_W, LINES);

  state_t            state;
  logic              req_store;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] resp_rdata;
  logic [31:0]       hit_cnt;
  logic [31:0]       miss_cnt;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [DATA_W-1:0] rd_data;
  logic              hit;
  logic              wr_en;
  logic              wr_fill;
  logic [DATA_W-1:0] wr_data;

  // Split the latched address into index and tag and evaluate hit
  always_comb begin
    idx = req_addr[IDX_W+1:2];
    tag = req_addr[ADDR_W-1:IDX_W+2];
    hit = rd_valid && (rd_tag == tag);
  end

  // Store hits update data in place; load responses fill the whole line
  always_comb begin
    wr_en   = 1'b0;
    wr_fill = 1'b0;
    wr_data = req_wdata;
    if (state == LOOKUP && req_store && hit) begin
      wr_en = 1'b1;
    end else if (state == MEM_WAIT && mem_l1_valid && !req_store) begin
      wr_en   = 1'b1;
      wr_fill = 1'b1;
      wr_data = mem_l1_rdata;
    end
  end

  l1_tag_data_array #(
    .LINES  (LINES),
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_fill  (wr_fill),
    .wr_idx   (idx),
    .wr_tag   (tag),
    .wr_data  (wr_data)
  );

  // Request sequencing, response capture and hit/miss accounting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_store  <= 1'b0;
      req_addr   <= '0;
      req_wdata  <= '0;
      resp_rdata <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req_valid) begin
            req_store <= cpu_req_store;
            req_addr  <= cpu_req_addr;
            req_wdata <= cpu_req_wdata;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (!req_store && hit) begin
            resp_rdata <= rd_data;
            hit_cnt    <= sat_inc(hit_cnt);
            state      <= RESP;
          end else begin
            if (!req_store) begin
              miss_cnt <= sat_inc(miss_cnt);
            end
            state <= MEM_REQ;
          end
        end
        MEM_REQ: begin
          state <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (mem_l1_valid) begin
            resp_rdata <= req_store ? '0 : mem_l1_rdata;
            state      <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from state and the latched request; the byte offset is forced to zero
  always_comb begin
    cpu_req_ready  = (state == IDLE);
    cpu_resp_valid = (state == RESP);
    cpu_resp_rdata = resp_rdata;
    l1_mem_valid   = (state == MEM_REQ);
    l1_mem_store   = req_store;
    l1_mem_addr    = req_addr & {{(ADDR_W-2){1'b1}}, 2'b00};
    l1_mem_wdata   = req_wdata;
    hit_count      = hit_cnt;
    miss_count     = miss_cnt;
  end

endmodule

// File: tb/tb_l1_cache_ctrl.sv
// tb/tb_l1_cache_ctrl.sv - directed self-checking bench for l1_cache_ctrl
module tb_l1_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req_valid = 1'b0;
  logic        cpu_req_store = 1'b0;
  logic [31:0] cpu_req_addr = '0;
  logic [31:0] cpu_req_wdata = '0;
  logic        cpu_req_ready;
  logic        cpu_resp_valid;
  logic [31:0] cpu_resp_rdata;
  logic        l1_mem_valid;
  logic        l1_mem_store;
  logic [31:0] l1_mem_addr;
  logic [31:0] l1_mem_wdata;
  logic [31:0] mem_l1_rdata = '0;
  logic        mem_l1_valid = 1'b0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int total = 0;
  int bad = 0;
  logic mem_stall = 1'b0;
  logic [31:0] mem [1024];

  always #5 clk = ~clk;

  l1_cache_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_store  (cpu_req_store),
    .cpu_req_addr   (cpu_req_addr),
    .cpu_req_wdata  (cpu_req_wdata),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_resp_rdata (cpu_resp_rdata),
    .l1_mem_valid   (l1_mem_valid),
    .l1_mem_store   (l1_mem_store),
    .l1_mem_addr    (l1_mem_addr),
    .l1_mem_wdata   (l1_mem_wdata),
    .mem_l1_rdata   (mem_l1_rdata),
    .mem_l1_valid   (mem_l1_valid),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  // Memory model: word i holds i, answers one cycle after each request pulse
  initial begin
    logic        pending;
    logic [31:0] pend_data;
    pending = 1'b0;
    pend_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        for (int i = 0; i < 1024; i++) mem[i] = i;
        pending = 1'b0;
        mem_l1_valid = 1'b0;
      end else begin
        mem_l1_valid = pending;
        mem_l1_rdata = pending ? pend_data : 32'h0;
        pending = 1'b0;
        if (l1_mem_valid && !mem_stall) begin
          pending = 1'b1;
          if (l1_mem_store) begin
            mem[l1_mem_addr[11:2]] = l1_mem_wdata;
            pend_data = 32'h0;
          end else begin
            pend_data = mem[l1_mem_addr[11:2]];
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic st, input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output int np,
                        output logic [31:0] ma, output logic ms, output logic [31:0] mw);
    @(negedge clk);
    cpu_req_valid = 1'b1;
    cpu_req_store = st;
    cpu_req_addr  = a;
    cpu_req_wdata = wd;
    @(posedge clk);
    #1;
    cpu_req_valid = 1'b0;
    lat = -1; rd = '0; np = 0; ma = '0; ms = 1'b0; mw = '0;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(negedge clk);
      if (l1_mem_valid) begin
        np++;
        if (np == 1) begin
          ma = l1_mem_addr; ms = l1_mem_store; mw = l1_mem_wdata;
          chk("mem_pulse_cycle", c, 2);
        end
      end
      if (cpu_resp_valid) begin
        lat = c;
        rd = cpu_resp_rdata;
      end
    end
  endtask

  initial begin
    int lat, np, seen;
    logic [31:0] rd, ma, mw;
    logic ms;

    repeat (3) @(negedge clk);
    chk("rst_ready", cpu_req_ready, 1);
    chk("rst_resp_valid", cpu_resp_valid, 0);
    chk("rst_mem_valid", l1_mem_valid, 0);
    chk("rst_rdata", cpu_resp_rdata, 0);
    chk("rst_mem_addr", l1_mem_addr, 0);
    chk("rst_hits", hit_count, 0);
    chk("rst_misses", miss_count, 0);
    rst_n = 1'b1;

    // cold load miss
    do_req(0, 32'h100, 0, lat, rd, np, ma, ms, mw);
    chk("ld1_lat", lat, 4); chk("ld1_rdata", rd, 32'h40); chk("ld1_np", np, 1);
    chk("ld1_maddr", ma, 32'h100); chk("ld1_mstore", ms, 0); chk("ld1_miss", miss_count, 1);

    // repeat load hits locally
    do_req(0, 32'h103, 0, lat, rd, np, ma, ms, mw);
    chk("ld2_lat", lat, 2); chk("ld2_rdata", rd, 32'h40); chk("ld2_np", np, 0);
    chk("ld2_hit", hit_count, 1); chk("ld2_miss", miss_count, 1);

    // store miss writes through without allocating
    do_req(1, 32'h104, 32'hDEADBEEF, lat, rd, np, ma, ms, mw);
    chk("st1_lat", lat, 4); chk("st1_rdata", rd, 0); chk("st1_np", np, 1);
    chk("st1_maddr", ma, 32'h104); chk("st1_mstore", ms, 1); chk("st1_mwdata", mw, 32'hDEADBEEF);
    chk("st1_miss", miss_count, 1);
    do_req(0, 32'h104, 0, lat, rd, np, ma, ms, mw);
    chk("ld3_lat", lat, 4); chk("ld3_rdata", rd, 32'hDEADBEEF); chk("ld3_np", np, 1);
    chk("ld3_miss", miss_count, 2);

    // store hit updates line and memory
    do_req(0, 32'h100, 0, lat, rd, np, ma, ms, mw);
    chk("ld4_lat", lat, 2); chk("ld4_rdata", rd, 32'h40);
    do_req(1, 32'h100, 32'h1234, lat, rd, np, ma, ms, mw);
    chk("st2_np", np, 1); chk("st2_mwdata", mw, 32'h1234); chk("st2_lat", lat, 4);
    do_req(0, 32'h100, 0, lat, rd, np, ma, ms, mw);
    chk("ld5_lat", lat, 2); chk("ld5_rdata", rd, 32'h1234); chk("ld5_np", np, 0);
    chk("ld5_hit", hit_count, 3); chk("ld5_mem", mem[32'h40], 32'h1234);

    // fresh reset and memory for the conflict scenario
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    do_req(0, 32'h100, 0, lat, rd, np, ma, ms, mw);
    chk("cf1_lat", lat, 4); chk("cf1_rdata", rd, 32'h40);
    do_req(0, 32'h200, 0, lat, rd, np, ma, ms, mw);
    chk("cf2_lat", lat, 4); chk("cf2_rdata", rd, 32'h80); chk("cf2_maddr", ma, 32'h200);
    do_req(0, 32'h100, 0, lat, rd, np, ma, ms, mw);
    chk("cf3_lat", lat, 4); chk("cf3_rdata", rd, 32'h40);
    chk("cf_miss", miss_count, 3); chk("cf_hit", hit_count, 0);

    // store with matching index but different tag leaves the line valid
    do_req(1, 32'h200, 32'h5555, lat, rd, np, ma, ms, mw);
    chk("st3_np", np, 1);
    do_req(0, 32'h100, 0, lat, rd, np, ma, ms, mw);
    chk("ld6_lat", lat, 2); chk("ld6_rdata", rd, 32'h40); chk("ld6_hit", hit_count, 1);

    // reset during MEM_WAIT of a load miss
    mem_stall = 1'b1;
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_req_store = 1'b0; cpu_req_addr = 32'h108;
    @(posedge clk);
    #1;
    cpu_req_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      @(negedge clk);
      if (l1_mem_valid) seen = 1;
    end
    chk("rs_mem_pulse", seen, 1);
    @(negedge clk); @(negedge clk);
    chk("rs_waiting", cpu_resp_valid, 0);
    rst_n = 1'b0;
    #1;
    chk("rs_ready", cpu_req_ready, 1);
    chk("rs_resp", cpu_resp_valid, 0);
    chk("rs_miss", miss_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_stall = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (cpu_resp_valid) seen++;
    end
    chk("rs_no_resp", seen, 0);
    do_req(0, 32'h108, 0, lat, rd, np, ma, ms, mw);
    chk("rs_ld_lat", lat, 4); chk("rs_ld_rdata", rd, 32'h42); chk("rs_ld_np", np, 1);
    chk("rs_ld_miss", miss_count, 1);
    do_req(0, 32'h100, 0, lat, rd, np, ma, ms, mw);
    chk("rs_ld2_lat", lat, 4); chk("rs_ld2_miss", miss_count, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
